// File: rtl/bist_sequencer.sv
// bist_sequencer: automatic BIST sequencer that drives the ring/Johnson/LFSR pattern
// generators phase by phase, compacts their output into a Galois MISR and checks each
// phase signature against a golden value.
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a run (accepted in IDLE or DONE only)
//   tick                     one-cycle pacing strobe
//   mode_sel                 00 all phases, 01 ring, 10 Johnson, 11 LFSR
//   pattern                  generator output compacted into the MISR
//   gen_rst                  one-cycle generator reset at each phase start
//   ring/johnson/lfsr enable generator advance strobes for the active phase
//   busy, done, pass         run active, run finished, all checked phases matched
//   phase                    active phase (00 when not busy)
//   signature                current MISR contents
module bist_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               DWELL     = 16,
    parameter logic [WIDTH-1:0] MISR_POLY = 16'hB400,
    parameter logic [WIDTH-1:0] MISR_SEED = 16'hFFFF,
    parameter logic [WIDTH-1:0] GOLD_RING = 16'h0000,
    parameter logic [WIDTH-1:0] GOLD_JOHN = 16'h0000,
    parameter logic [WIDTH-1:0] GOLD_LFSR = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tick,
    input  logic [1:0]       mode_sel,
    input  logic [WIDTH-1:0] pattern,
    output logic             gen_rst,
    output logic             ring_counter_enable,
    output logic             johnson_counter_enable,
    output logic             lfsr_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       phase,
    output logic [WIDTH-1:0] signature
);
    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       phase_q, phase_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic             fail_q, fail_d;
    logic             absorb_q, absorb_d;
    logic             strobe;
    logic [WIDTH-1:0] golden;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
            misr_q   <= '0;
            fail_q   <= 1'b0;
            absorb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            misr_q   <= misr_d;
            fail_q   <= fail_d;
            absorb_q <= absorb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        strobe   = (state_q == RUN) && tick;
        // the generator output moves one cycle after its strobe, so absorb then
        absorb_d = strobe;
        misr_d   = absorb_q ? ({misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? MISR_POLY : '0) ^ pattern)
                            : misr_q;
        golden   = phase_q == 2'b01 ? GOLD_RING : phase_q == 2'b10 ? GOLD_JOHN : GOLD_LFSR;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d  = mode_sel;
                    phase_d = mode_sel == 2'b00 ? 2'b01 : mode_sel;
                    fail_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                misr_d  = MISR_SEED;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (strobe) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = cnt_q == CW'(DWELL - 1) ? CAPT : RUN;
                end
            end
            CAPT: state_d = CHECK;
            CHECK: begin
                fail_d = fail_q | (misr_q != golden);
                if (mode_q == 2'b00 && phase_q != 2'b11) begin
                    phase_d = phase_q + 2'b01;
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy                   = state_q != IDLE && state_q != DONE;
    assign done                   = state_q == DONE;
    assign pass                   = done && !fail_q;
    assign gen_rst                = state_q == LOAD;
    assign ring_counter_enable    = strobe && phase_q == 2'b01;
    assign johnson_counter_enable = strobe && phase_q == 2'b10;
    assign lfsr_enable            = strobe && phase_q == 2'b11;
    assign phase                  = busy ? phase_q : 2'b00;
    assign signature              = misr_q;
endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: directed table-driven bench for bist_sequencer with behavioural pattern generators
module tb_bist_sequencer;
    function automatic logic [15:0] gen_init(input logic [1:0] p);
        return p == 2'd2 ? 16'h0000 : 16'h0001;
    endfunction

    function automatic logic [15:0] gen_step(input logic [1:0] p, input logic [15:0] g);
        return p == 2'd1 ? {g[14:0], g[15]} :
               p == 2'd2 ? {g[14:0], ~g[15]} : {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'hB400 : 16'h0000) ^ d;
    endfunction

    function automatic logic [15:0] sig_fn(input logic [1:0] p, input int n);
        logic [15:0] g, m;
        g = gen_init(p);
        m = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            g = gen_step(p, g);
            m = misr_step(m, g);
        end
        return m;
    endfunction

    localparam logic [15:0] G_R = sig_fn(2'd1, 4);
    localparam logic [15:0] G_J = sig_fn(2'd2, 4);
    localparam logic [15:0] G_L = sig_fn(2'd3, 4);
    localparam logic [15:0] G_C = sig_fn(2'd1, 16);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, tick, clr, start_c, tick_c;
    logic [1:0] mode_sel, mode_c;
    logic [15:0] pattern, pattern_c;
    logic gen_rst_a, ring_a, john_a, lfsr_a, busy_a, done_a, pass_a;
    logic gen_rst_b, ring_b, john_b, lfsr_b, busy_b, done_b, pass_b;
    logic gen_rst_c, ring_c, john_c, lfsr_c, busy_c, done_c, pass_c;
    logic [1:0] phase_a, phase_b, phase_c;
    logic [15:0] sig_a, sig_b, sig_c;

    bist_sequencer #(.DWELL(4), .GOLD_RING(G_R), .GOLD_JOHN(G_J), .GOLD_LFSR(G_L)) u_a (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .mode_sel(mode_sel), .pattern(pattern),
        .gen_rst(gen_rst_a), .ring_counter_enable(ring_a), .johnson_counter_enable(john_a),
        .lfsr_enable(lfsr_a), .busy(busy_a), .done(done_a), .pass(pass_a), .phase(phase_a),
        .signature(sig_a));

    bist_sequencer #(.DWELL(4), .GOLD_RING(G_R), .GOLD_JOHN(G_J ^ 16'h0001), .GOLD_LFSR(G_L)) u_b (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .mode_sel(mode_sel), .pattern(pattern),
        .gen_rst(gen_rst_b), .ring_counter_enable(ring_b), .johnson_counter_enable(john_b),
        .lfsr_enable(lfsr_b), .busy(busy_b), .done(done_b), .pass(pass_b), .phase(phase_b),
        .signature(sig_b));

    bist_sequencer #(.DWELL(16)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .tick(tick_c), .mode_sel(mode_c), .pattern(pattern_c),
        .gen_rst(gen_rst_c), .ring_counter_enable(ring_c), .johnson_counter_enable(john_c),
        .lfsr_enable(lfsr_c), .busy(busy_c), .done(done_c), .pass(pass_c), .phase(phase_c),
        .signature(sig_c));

    logic [15:0] ring_m, john_m, lfsr_m, ring_cm;
    always @(posedge clk) begin
        if (gen_rst_a) begin
            ring_m <= gen_init(2'd1);
            john_m <= gen_init(2'd2);
            lfsr_m <= gen_init(2'd3);
        end else begin
            if (ring_a) ring_m <= gen_step(2'd1, ring_m);
            if (john_a) john_m <= gen_step(2'd2, john_m);
            if (lfsr_a) lfsr_m <= gen_step(2'd3, lfsr_m);
        end
        if (gen_rst_c) ring_cm <= gen_init(2'd1);
        else if (ring_c) ring_cm <= gen_step(2'd1, ring_cm);
    end
    assign pattern   = phase_a == 2'd1 ? ring_m : phase_a == 2'd2 ? john_m : lfsr_m;
    assign pattern_c = ring_cm;

    int n_ring, n_john, n_lfsr, n_grst, c_ring, c_john, c_lfsr, c_grst;
    logic [5:0] seq;
    always @(posedge clk) begin
        if (clr) begin
            n_ring <= 0; n_john <= 0; n_lfsr <= 0; n_grst <= 0; seq <= '0;
        end else begin
            n_ring <= n_ring + int'(ring_a);
            n_john <= n_john + int'(john_a);
            n_lfsr <= n_lfsr + int'(lfsr_a);
            n_grst <= n_grst + int'(gen_rst_a);
            if (gen_rst_a) seq <= {seq[3:0], phase_a};
        end
        if (rst) begin
            c_ring <= 0; c_john <= 0; c_lfsr <= 0; c_grst <= 0;
        end else begin
            c_ring <= c_ring + int'(ring_c);
            c_john <= c_john + int'(john_c);
            c_lfsr <= c_lfsr + int'(lfsr_c);
            c_grst <= c_grst + int'(gen_rst_c);
        end
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          per;
        int          nr, nj, nl, ng;
        logic [5:0]  seq;
        logic        pa, pb;
        logic [15:0] sig;
    } vec_t;
    vec_t vt[5];

    task automatic apply(input vec_t v, input bit poke);
        clr = 1'b1;
        mode_sel = v.mode;
        start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        chk("load_state", {29'd0, gen_rst_a, busy_a, done_a},
            {29'd0, 3'b110});
        chk("load_phase", {30'd0, phase_a}, {30'd0, v.mode == 2'b00 ? 2'b01 : v.mode});
        for (int cyc = 0; cyc < 3000 && !done_a; cyc++) begin
            tick = (v.per == 1) || (cyc % v.per == 0);
            start = poke && cyc >= 5 && cyc <= 7;
            mode_sel = (poke && cyc >= 3) ? ~v.mode : v.mode;
            @(negedge clk);
        end
        tick = 1'b0;
        start = 1'b0;
        mode_sel = v.mode;
        chk("done", {31'd0, done_a}, 32'd1);
        chk("n_ring", n_ring, v.nr);
        chk("n_john", n_john, v.nj);
        chk("n_lfsr", n_lfsr, v.nl);
        chk("n_gen_rst", n_grst, v.ng);
        chk("phase_seq", {26'd0, seq}, {26'd0, v.seq});
        chk("pass_a", {31'd0, pass_a}, {31'd0, v.pa});
        chk("pass_b", {31'd0, pass_b}, {31'd0, v.pb});
        chk("done_b", {31'd0, done_b}, 32'd1);
        chk("signature", {16'd0, sig_a}, {16'd0, v.sig});
        chk("idle_outs", {28'd0, busy_a, phase_a, gen_rst_a}, 32'd0);
    endtask

    initial begin
        vt[0] = '{2'b01, 4, 4, 0, 0, 1, 6'b000001, 1'b1, 1'b1, G_R};
        vt[1] = '{2'b00, 1, 4, 4, 4, 3, 6'b011011, 1'b1, 1'b0, G_L};
        vt[2] = '{2'b10, 3, 0, 4, 0, 1, 6'b000010, 1'b1, 1'b0, G_J};
        vt[3] = '{2'b11, 2, 0, 0, 4, 1, 6'b000011, 1'b1, 1'b1, G_L};
        vt[4] = '{2'b00, 5, 4, 4, 4, 3, 6'b011011, 1'b1, 1'b0, G_L};
        rst = 1'b1; start = 1'b0; tick = 1'b0; clr = 1'b1; mode_sel = 2'b00;
        start_c = 1'b0; tick_c = 1'b0; mode_c = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_a", {7'd0, gen_rst_a, ring_a, john_a, lfsr_a, busy_a, done_a, pass_a, phase_a, sig_a}, 32'd0);
        chk("reset_c", {7'd0, gen_rst_c, ring_c, john_c, lfsr_c, busy_c, done_c, pass_c, phase_c, sig_c}, 32'd0);
        rst = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        chk("idle_ignores_tick", {28'd0, ring_a, john_a, lfsr_a, busy_a}, 32'd0);
        tick = 1'b0;

        mode_c = 2'b01;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done_c; cyc++) begin
            tick_c = (cyc % 4 == 0);
            @(negedge clk);
        end
        tick_c = 1'b0;
        chk("c_done", {31'd0, done_c}, 32'd1);
        chk("c_ring", c_ring, 16);
        chk("c_john", c_john, 0);
        chk("c_lfsr", c_lfsr, 0);
        chk("c_gen_rst", c_grst, 1);
        chk("c_signature", {16'd0, sig_c}, {16'd0, G_C});
        chk("c_pass", {31'd0, pass_c}, {31'd0, G_C == 16'h0000});

        for (int i = 0; i < 5; i++) apply(vt[i], 1'b0);

        apply(vt[0], 1'b1);

        clr = 1'b1;
        mode_sel = 2'b00;
        start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 200 && n_john == 0; i++) @(negedge clk);
        chk("reach_john", {31'd0, n_john != 0}, 32'd1);
        chk("mid_phase", {30'd0, phase_a}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_a", {7'd0, gen_rst_a, ring_a, john_a, lfsr_a, busy_a, done_a, pass_a, phase_a, sig_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {7'd0, gen_rst_a, ring_a, john_a, lfsr_a, busy_a, done_a, pass_a, phase_a, sig_a}, 32'd0);
        tick = 1'b0;
        apply(vt[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
